seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver.sv | 124 ++++++++++++
 tb/tb_seg_scan_driver.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes eight 4-bit digit codes onto a common-anode
// seven-segment display with per-frame snapshots, ghost blanking and a DP mask.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV  = 25000,
  parameter int unsigned BLANK_CYC = 250,
  parameter logic [7:0]  DP_MASK   = 8'b00000100
) (
  input  logic        segclk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] segdata,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned   CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [31:0]   r_frame;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_start;

  logic          w_cnt_wrap;
  logic          w_snapshot;
  logic          w_drive;
  logic [3:0]    w_nibbles [8];
  logic [7:0]    w_an_sel;
  logic [3:0]    w_cur_nibble;
  logic [6:0]    w_glyph;
  logic [7:0]    w_an_next;
  logic [6:0]    w_seg_next;
  logic          w_dp_next;

  assign w_cnt_wrap = (r_cnt == CNT_MAX);
  assign w_snapshot = (r_cnt == '0) && (r_idx == 3'd0);
  // Blanking window at the start of every slot keeps the previous digit's
  // segment pattern from ghosting onto the next anode.
  assign w_drive    = en && (r_cnt >= BLANK_LIM);

  // Per-digit nibble slices of the snapshot and the active-low anode decode.
  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    assign w_nibbles[gi] = r_frame[4*gi +: 4];
    assign w_an_sel[gi]  = (r_idx != 3'(gi));
  end

  assign w_cur_nibble = w_nibbles[r_idx];

  // Active-low {g,f,e,d,c,b,a}; codes A..F carry the team glyphs.
  always_comb begin
    w_glyph = 7'b1111111;
    case (w_cur_nibble)
      4'h0: w_glyph = 7'b1000000;
      4'h1: w_glyph = 7'b1111001;
      4'h2: w_glyph = 7'b0100100;
      4'h3: w_glyph = 7'b0110000;
      4'h4: w_glyph = 7'b0011001;
      4'h5: w_glyph = 7'b0010010;
      4'h6: w_glyph = 7'b0000010;
      4'h7: w_glyph = 7'b1111000;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0010000;
      4'hA: w_glyph = 7'b0111111;
      4'hB: w_glyph = 7'b0101011;
      4'hC: w_glyph = 7'b0100011;
      4'hD: w_glyph = 7'b0000110;
      4'hE: w_glyph = 7'b0001100;
      default: w_glyph = 7'b1111111;
    endcase
  end

  always_comb begin
    w_an_next  = 8'hFF;
    w_seg_next = 7'h7F;
    w_dp_next  = 1'b1;
    if (w_drive) begin
      w_an_next  = w_an_sel;
      w_seg_next = w_glyph;
      w_dp_next  = ~DP_MASK[r_idx];
    end
  end

  always_ff @(posedge segclk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_idx         <= 3'd0;
      r_frame       <= 32'hFFFF_FFFF;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt <= w_cnt_wrap ? '0 : r_cnt + CW'(1);
      if (w_cnt_wrap) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_snapshot) begin
        r_frame <= segdata;
      end
      r_frame_start <= w_snapshot;
    end
  end

  always_ff @(posedge segclk or posedge reset) begin
    if (reset) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a cycle model pushes expected outputs
// to a scoreboard each edge; scenario tasks pop and compare on the falling edge.
module tb_seg_scan_driver;

  localparam int SCAN_DIV = 4;
  localparam int BLANK    = 1;

  localparam logic [6:0] GLYPH_REF [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0101011,
    7'b0100011, 7'b0000110, 7'b0001100, 7'b1111111};
  localparam logic [7:0] STATIC_AN [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  localparam logic [6:0] STATIC_SEG [8] = '{
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001,
    7'b0000110, 7'b0101011, 7'b0100011, 7'b0101011};
  localparam logic [6:0] NEW_SEG [8] = '{
    7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b1111111, 7'b0001100, 7'b1111001, 7'b1111111};

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    logic       drv;
    logic [2:0] slot;
  } exp_t;

  logic        segclk;
  logic        reset;
  logic        en;
  logic [31:0] segdata;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  exp_t        sb [$];
  int          m_cnt;
  logic [2:0]  m_idx;
  logic [31:0] m_frame;
  logic [7:0]  dp_mask_ref;
  logic [7:0]  static_dp;
  int          n_pass;
  int          n_total;

  seg_scan_driver #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK),
    .DP_MASK  (8'b00000100)
  ) dut (
    .segclk     (segclk),
    .reset      (reset),
    .en         (en),
    .segdata    (segdata),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_start(frame_start)
  );

  initial segclk = 1'b0;
  always #5 segclk = ~segclk;

  task automatic model_reset();
    m_cnt   = 0;
    m_idx   = 3'd0;
    m_frame = 32'hFFFF_FFFF;
    sb.delete();
  endtask

  // Predict the outputs produced by the next edge, then step the model across it.
  task automatic advance();
    exp_t       e;
    logic [7:0] one;
    logic [3:0] nib;
    one    = 8'd1;
    nib    = 4'(m_frame >> (4 * m_idx));
    e.slot = m_idx;
    e.fs   = (m_cnt == 0) && (m_idx == 3'd0);
    e.drv  = (m_cnt >= BLANK) && en;
    e.an   = e.drv ? ~(one << m_idx) : 8'hFF;
    e.seg  = e.drv ? GLYPH_REF[nib] : 7'h7F;
    e.dp   = e.drv ? ~dp_mask_ref[m_idx] : 1'b1;
    sb.push_back(e);
    if (e.fs) m_frame = segdata;
    if (m_cnt == SCAN_DIV - 1) begin
      m_cnt = 0;
      m_idx = m_idx + 3'd1;
    end else begin
      m_cnt = m_cnt + 1;
    end
    @(posedge segclk);
    @(negedge segclk);
  endtask

  task automatic test_reset();
    exp_t e;
    reset   = 1'b1;
    en      = 1'b0;
    segdata = 32'h0;
    repeat (3) @(negedge segclk);
    n_total++; if (an !== 8'hFF) $display("FAIL reset.an got=%h exp=%h", an, 8'hFF); else n_pass++;
    n_total++; if (seg !== 7'h7F) $display("FAIL reset.seg got=%b exp=%b", seg, 7'h7F); else n_pass++;
    n_total++; if (dp !== 1'b1) $display("FAIL reset.dp got=%b exp=1", dp); else n_pass++;
    n_total++; if (frame_start !== 1'b0) $display("FAIL reset.frame_start got=%b exp=0", frame_start); else n_pass++;
    segdata = 32'hBCBD_1234;
    en      = 1'b1;
    reset   = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      advance();
      e = sb.pop_front();
      n_total++; if (frame_start !== (i == 0)) $display("FAIL reset.fs_pulse cyc=%0d got=%b exp=%b", i, frame_start, (i == 0)); else n_pass++;
      n_total++; if (an !== e.an) $display("FAIL reset.an_run cyc=%0d got=%h exp=%h", i, an, e.an); else n_pass++;
    end
    $display("test_reset: reset state and first snapshot pulse compared");
  endtask

  task automatic test_static();
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      advance();
      e = sb.pop_front();
      n_total++; if (an !== e.an) $display("FAIL static.an slot=%0d got=%h exp=%h", e.slot, an, e.an); else n_pass++;
      n_total++; if (seg !== e.seg) $display("FAIL static.seg slot=%0d got=%b exp=%b", e.slot, seg, e.seg); else n_pass++;
      n_total++; if (dp !== e.dp) $display("FAIL static.dp slot=%0d got=%b exp=%b", e.slot, dp, e.dp); else n_pass++;
      n_total++; if (frame_start !== e.fs) $display("FAIL static.fs slot=%0d got=%b exp=%b", e.slot, frame_start, e.fs); else n_pass++;
      if (e.drv) begin
        n_total++; if (an !== STATIC_AN[e.slot]) $display("FAIL static.an_tbl slot=%0d got=%h exp=%h", e.slot, an, STATIC_AN[e.slot]); else n_pass++;
        n_total++; if (seg !== STATIC_SEG[e.slot]) $display("FAIL static.seg_tbl slot=%0d got=%b exp=%b", e.slot, seg, STATIC_SEG[e.slot]); else n_pass++;
        n_total++; if (dp !== static_dp[e.slot]) $display("FAIL static.dp_tbl slot=%0d got=%b exp=%b", e.slot, dp, static_dp[e.slot]); else n_pass++;
      end
    end
    $display("test_static: two frames of 32'hBCBD_1234 compared");
  endtask

  task automatic test_tearing();
    exp_t e;
    logic changed;
    logic use_new;
    changed = 1'b0;
    use_new = 1'b0;
    for (int i = 0; i < 96; i++) begin
      if (!changed && m_idx == 3'd3 && m_cnt == 2) begin
        segdata = 32'hF1EF_5678;
        changed = 1'b1;
      end
      advance();
      e = sb.pop_front();
      if (e.fs && changed) use_new = 1'b1;
      n_total++; if (an !== e.an) $display("FAIL tear.an slot=%0d got=%h exp=%h", e.slot, an, e.an); else n_pass++;
      n_total++; if (frame_start !== e.fs) $display("FAIL tear.fs slot=%0d got=%b exp=%b", e.slot, frame_start, e.fs); else n_pass++;
      if (e.drv) begin
        n_total++;
        if (seg !== (use_new ? NEW_SEG[e.slot] : STATIC_SEG[e.slot]))
          $display("FAIL tear.seg slot=%0d new=%0b got=%b exp=%b", e.slot, use_new, seg, use_new ? NEW_SEG[e.slot] : STATIC_SEG[e.slot]);
        else n_pass++;
      end
    end
    n_total++; if (use_new !== 1'b1) $display("FAIL tear.new_frame got=%b exp=1", use_new); else n_pass++;
    $display("test_tearing: mid-frame segdata change held off until next snapshot");
  endtask

  task automatic test_enable();
    exp_t e;
    int   off_left;
    logic started;
    int   fs_seen;
    off_left = 0;
    started  = 1'b0;
    fs_seen  = 0;
    for (int i = 0; i < 80; i++) begin
      if (!started && m_idx == 3'd2 && m_cnt == 2) begin
        en       = 1'b0;
        started  = 1'b1;
        off_left = 10;
      end
      advance();
      e = sb.pop_front();
      if (e.fs) fs_seen++;
      if (off_left > 0) begin
        n_total++; if (an !== 8'hFF || seg !== 7'h7F) $display("FAIL enable.off an=%h seg=%b exp=ff/7f", an, seg); else n_pass++;
        off_left--;
        if (off_left == 0) en = 1'b1;
      end
      n_total++; if (an !== e.an) $display("FAIL enable.an slot=%0d got=%h exp=%h", e.slot, an, e.an); else n_pass++;
      n_total++; if (seg !== e.seg) $display("FAIL enable.seg slot=%0d got=%b exp=%b", e.slot, seg, e.seg); else n_pass++;
      n_total++; if (frame_start !== e.fs) $display("FAIL enable.fs slot=%0d got=%b exp=%b", e.slot, frame_start, e.fs); else n_pass++;
    end
    n_total++; if (fs_seen < 2) $display("FAIL enable.fs_count got=%0d exp>=2", fs_seen); else n_pass++;
    $display("test_enable: 10-cycle disable window compared, %0d snapshots", fs_seen);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   guard;
    logic found;
    guard = 0;
    while (!(m_idx == 3'd5 && m_cnt == 2) && guard < 64) begin
      advance();
      e = sb.pop_front();
      guard++;
      n_total++; if (an !== e.an) $display("FAIL rmid.pre_an slot=%0d got=%h exp=%h", e.slot, an, e.an); else n_pass++;
    end
    n_total++; if (an !== 8'hDF) $display("FAIL rmid.driving got=%h exp=%h", an, 8'hDF); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if (an !== 8'hFF) $display("FAIL rmid.async_an got=%h exp=%h", an, 8'hFF); else n_pass++;
    n_total++; if (seg !== 7'h7F) $display("FAIL rmid.async_seg got=%b exp=%b", seg, 7'h7F); else n_pass++;
    n_total++; if (dp !== 1'b1) $display("FAIL rmid.async_dp got=%b exp=1", dp); else n_pass++;
    segdata = 32'h2345_67C9;
    repeat (3) @(negedge segclk);
    reset = 1'b0;
    model_reset();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      advance();
      e = sb.pop_front();
      n_total++; if (an !== e.an) $display("FAIL rmid.an slot=%0d got=%h exp=%h", e.slot, an, e.an); else n_pass++;
      n_total++; if (seg !== e.seg) $display("FAIL rmid.seg slot=%0d got=%b exp=%b", e.slot, seg, e.seg); else n_pass++;
      if (!found && an !== 8'hFF) begin
        found = 1'b1;
        n_total++; if (an !== 8'hFE || seg !== 7'b0010000) $display("FAIL rmid.first_digit an=%h seg=%b exp=fe/0010000", an, seg); else n_pass++;
      end
    end
    n_total++; if (!found) $display("FAIL rmid.no_drive got=0 exp=1"); else n_pass++;
    $display("test_reset_mid: asynchronous reset during digit 5 and restart compared");
  endtask

  task automatic test_glyph();
    exp_t e;
    logic seen_fs;
    logic found;
    int   guard;
    for (int k = 0; k < 16; k++) begin
      segdata = 32'hFFFF_FFF0 | 32'(k);
      seen_fs = 1'b0;
      found   = 1'b0;
      guard   = 0;
      while (!found && guard < 80) begin
        advance();
        e = sb.pop_front();
        guard++;
        n_total++; if (an !== e.an) $display("FAIL glyph.an code=%0h got=%h exp=%h", k, an, e.an); else n_pass++;
        n_total++; if (!(an === 8'hFF || $onehot(~an))) $display("FAIL glyph.onehot got=%h exp=onehot-low", an); else n_pass++;
        if (e.fs) seen_fs = 1'b1;
        else if (seen_fs && e.drv && e.slot == 3'd0) begin
          found = 1'b1;
          n_total++; if (seg !== GLYPH_REF[k]) $display("FAIL glyph.seg code=%0h got=%b exp=%b", k, seg, GLYPH_REF[k]); else n_pass++;
        end
      end
      n_total++; if (!found) $display("FAIL glyph.timeout code=%0h got=0 exp=1", k); else n_pass++;
      $display("glyph code %0h: seg=%b", k, seg);
    end
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    dp_mask_ref = 8'b00000100;
    static_dp   = 8'b11111011;
    model_reset();
    test_reset();
    test_static();
    test_tearing();
    test_enable();
    test_reset_mid();
    test_glyph();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
